// File: rtl/router_pkg.sv
// router_pkg
//  Shared definitions for the router packet register.
//  - DEF_DATA_WIDTH / DEF_ADDR_BITS : default beat and header-address widths
//  - CHECK_XOR / CHECK_ROTXOR       : check-mode encodings
//  - check_step()                   : one step of the running check over a beat
//  check_step works on a fixed STEP_W-bit container. Callers cast the result
//  back to their own beat width, which limits beats to at most STEP_W bits.
package router_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 2;
  localparam int STEP_W         = 32;

  localparam logic CHECK_XOR    = 1'b0;
  localparam logic CHECK_ROTXOR = 1'b1;

  // XOR mode:        acc ^ beat
  // rotate-XOR mode: rotl(acc, 1) ^ beat, where the rotate wraps at 'width' bits
  function automatic logic [STEP_W-1:0] check_step(
    input logic              mode,
    input logic [STEP_W-1:0] acc,
    input logic [STEP_W-1:0] beat,
    input int                width
  );
    logic [STEP_W-1:0] mask;
    logic [STEP_W-1:0] rot;
    // When width == STEP_W the shift overflows to 0 and the subtraction
    // wraps to all-ones, which is the right mask for a full-width beat.
    mask = (STEP_W'(1) << width) - STEP_W'(1);
    rot  = ((acc << 1) | (acc >> (width - 1))) & mask;
    if (mode == CHECK_ROTXOR) begin
      check_step = (rot ^ beat) & mask;
    end else begin
      check_step = (acc ^ beat) & mask;
    end
  endfunction

endpackage

// File: rtl/router_chk_acc.sv
// router_chk_acc
//  Running check accumulator and payload-beat counter for one packet.
//  Ports:
//   clk, resetn  clock / asynchronous active-low reset
//   clear        valid header accepted: zero acc and pay_cnt
//   seed         first-data cycle: acc <= step(0, hdr)
//   step_en      payload beat accepted: acc <= step(acc, data_in), pay_cnt + 1
//   hdr          latched header beat
//   data_in      current input beat
//   acc          running check value
//   pay_cnt      payload beats seen, saturating at all-ones
module router_chk_acc import router_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int CHECK_MODE = 0
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            clear,
  input  logic                            seed,
  input  logic                            step_en,
  input  logic [DATA_WIDTH-1:0]           hdr,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic [DATA_WIDTH-1:0]           acc,
  output logic [DATA_WIDTH-ADDR_BITS-1:0] pay_cnt
);

  localparam int   LEN_W = DATA_WIDTH - ADDR_BITS;
  localparam logic MODE  = (CHECK_MODE != 0) ? CHECK_ROTXOR : CHECK_XOR;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      pay_cnt <= '0;
    end else if (clear) begin
      acc     <= '0;
      pay_cnt <= '0;
    end else if (seed) begin
      acc <= DATA_WIDTH'(check_step(MODE, '0, STEP_W'(hdr), DATA_WIDTH));
    end else if (step_en) begin
      acc <= DATA_WIDTH'(check_step(MODE, STEP_W'(acc), STEP_W'(data_in), DATA_WIDTH));
      if (pay_cnt != '1) begin
        pay_cnt <= pay_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/router_pkt_reg.sv
// router_pkt_reg
//  Packet register between the router input and the FIFO write ports.
//  Latches the header, forwards header then payload to the FIFO one beat per
//  cycle (1-cycle latency), parks one beat in 'hold' across a FIFO-full stall,
//  and checks the trailing check beat and the payload length.
//  The state inputs are one-hot decodes of the external router FSM.
//  Ports:
//   clk, resetn      clock / asynchronous active-low reset
//   pkt_valid        source beat valid; low while the check beat is presented
//   fifo_full        selected FIFO full
//   detect_add, lfd_state, ld_state, full_state, laf_state   FSM state decodes
//   rst_int_reg      clears low_pkt_valid
//   data_in          input beat
//   data_out         beat to FIFO
//   parity_done      check beat captured for the current packet
//   low_pkt_valid    check beat arrived in LOAD_DATA
//   err              check mismatch
//   len_err          payload beat count != header payload length
//   err_cnt          count of packets with err or len_err, saturating
module router_pkt_reg import router_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = 3,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int CHECK_MODE = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  full_state,
  input  logic                  laf_state,
  input  logic                  rst_int_reg,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic                  len_err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int LEN_W = DATA_WIDTH - ADDR_BITS;

  logic [DATA_WIDTH-1:0] hdr;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] acc;
  logic [LEN_W-1:0]      pay_cnt;

  logic                  hdr_ok;
  logic                  step_en;
  logic                  ld_cap;
  logic                  laf_cap;
  logic                  evt;
  logic [DATA_WIDTH-1:0] chk_value;
  logic                  chk_bad;
  logic                  len_bad;

  // A header with an out-of-range address is dropped without touching any state.
  assign hdr_ok = detect_add & pkt_valid &
                  ({1'b0, data_in[ADDR_BITS-1:0]} < (ADDR_BITS+1)'(NUM_CH));

  // Each payload beat is accumulated exactly once, on the LOAD_DATA cycle it
  // is presented, even if the FIFO is full; the stall/replay cycles never
  // accumulate, so a held beat is not counted twice.
  assign step_en = ld_state & pkt_valid & ~full_state & ~laf_state;

  // Check beat capture: straight from the input when the FIFO can take it,
  // otherwise from 'hold' once LOAD_AFTER_FULL replays it.
  assign ld_cap    = ld_state & ~pkt_valid & ~fifo_full;
  assign laf_cap   = laf_state & low_pkt_valid;
  assign evt       = ~parity_done & (ld_cap | laf_cap);
  assign chk_value = ld_cap ? data_in : hold;
  assign chk_bad   = (chk_value != acc);
  assign len_bad   = (pay_cnt != hdr[DATA_WIDTH-1:ADDR_BITS]);

  router_chk_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS),
    .CHECK_MODE (CHECK_MODE)
  ) u_chk_acc (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (hdr_ok),
    .seed    (lfd_state),
    .step_en (step_en),
    .hdr     (hdr),
    .data_in (data_in),
    .acc     (acc),
    .pay_cnt (pay_cnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hdr           <= '0;
      hold          <= '0;
      data_out      <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
      err_cnt       <= '0;
    end else begin
      if (hdr_ok) begin
        hdr <= data_in;
      end

      // One beat per cycle towards the FIFO; a beat that meets a full FIFO is
      // parked in 'hold' and replayed in LOAD_AFTER_FULL.
      if (lfd_state) begin
        data_out <= hdr;
      end else if (ld_state && !fifo_full) begin
        data_out <= data_in;
      end else if (ld_state) begin
        hold <= data_in;
      end else if (laf_state) begin
        data_out <= hold;
      end

      // Flags are sticky until the next accepted header.
      if (hdr_ok) begin
        parity_done <= 1'b0;
        err         <= 1'b0;
        len_err     <= 1'b0;
      end else if (evt) begin
        parity_done <= 1'b1;
        err         <= chk_bad;
        len_err     <= len_bad;
        if ((chk_bad || len_bad) && (err_cnt != '1)) begin
          err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
      end

      if (rst_int_reg) begin
        low_pkt_valid <= 1'b0;
      end else if (ld_state && !pkt_valid) begin
        low_pkt_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_reg.sv
// tb_router_pkt_reg
//  Bench for router_pkt_reg. Three instances share one stimulus bus:
//   dut0: defaults (8-bit, 3 channels, XOR check, 8-bit error counter)
//   dut1: as dut0 with a 2-bit error counter (saturation)
//   dut2: 16-bit, 4 channels, rotate-XOR check
//  Phase 0 exercises dut0/dut1, phase 1 exercises dut2.
module tb_router_pkt_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic        full_state, laf_state, rst_int_reg;
  logic [15:0] din;

  logic [7:0]  do0, do1;
  logic [15:0] do2;
  logic        pd0, pd1, pd2, lpv0, lpv1, lpv2;
  logic        er0, er1, er2, le0, le1, le2;
  logic [7:0]  ec0, ec2;
  logic [1:0]  ec1;

  router_pkt_reg dut0 (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .data_in(din[7:0]), .data_out(do0), .parity_done(pd0), .low_pkt_valid(lpv0),
    .err(er0), .len_err(le0), .err_cnt(ec0)
  );

  router_pkt_reg #(.ERR_CNT_W(2)) dut1 (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .data_in(din[7:0]), .data_out(do1), .parity_done(pd1), .low_pkt_valid(lpv1),
    .err(er1), .len_err(le1), .err_cnt(ec1)
  );

  router_pkt_reg #(.DATA_WIDTH(16), .NUM_CH(4), .ADDR_BITS(2), .CHECK_MODE(1)) dut2 (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .data_in(din), .data_out(do2), .parity_done(pd2), .low_pkt_valid(lpv2),
    .err(er2), .len_err(le2), .err_cnt(ec2)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];      // expected data_out, one entry per driven cycle
  logic [15:0] exp_do = '0;
  logic        exp_pd = 1'b0, exp_lpv = 1'b0, exp_err = 1'b0, exp_lerr = 1'b0;
  int          bad_pkts = 0;
  logic [15:0] m_hdr = '0;
  int          phase = 0;
  bit          cmp_en = 1'b0;
  logic [15:0] pay[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Check value of a packet straight from the rule: fold the header, then
  // every payload beat, into a running value of the given width.
  function automatic logic [15:0] model_check(input logic [15:0] hdr, input int w, input bit rot);
    int unsigned m, a;
    m = (32'd1 << w) - 32'd1;
    a = 0;
    a = rot ? ((((a << 1) | (a >> (w - 1))) & m) ^ 32'(hdr)) : (a ^ 32'(hdr));
    foreach (pay[i]) begin
      a = rot ? ((((a << 1) | (a >> (w - 1))) & m) ^ 32'(pay[i])) : (a ^ 32'(pay[i]));
    end
    return 16'(a & m);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    logic [15:0] e;
    if (cmp_en && resetn) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (phase == 0) begin
          chk("data_out0", 32'(do0), 32'(e[7:0]));
          chk("data_out1", 32'(do1), 32'(e[7:0]));
        end else begin
          chk("data_out2", 32'(do2), 32'(e));
        end
      end
      if (phase == 0) begin
        chk("parity_done0", 32'(pd0), 32'(exp_pd));
        chk("low_pkt_valid0", 32'(lpv0), 32'(exp_lpv));
        chk("err0", 32'(er0), 32'(exp_err));
        chk("len_err0", 32'(le0), 32'(exp_lerr));
        chk("err_cnt0", 32'(ec0), 32'(sat(bad_pkts, 255)));
        chk("parity_done1", 32'(pd1), 32'(exp_pd));
        chk("err1", 32'(er1), 32'(exp_err));
        chk("len_err1", 32'(le1), 32'(exp_lerr));
        chk("err_cnt1", 32'(ec1), 32'(sat(bad_pkts, 3)));
      end else begin
        chk("parity_done2", 32'(pd2), 32'(exp_pd));
        chk("low_pkt_valid2", 32'(lpv2), 32'(exp_lpv));
        chk("err2", 32'(er2), 32'(exp_err));
        chk("len_err2", 32'(le2), 32'(exp_lerr));
        chk("err_cnt2", 32'(ec2), 32'(sat(bad_pkts, 255)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_clear();
    pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0; ld_state = 0;
    full_state = 0; laf_state = 0; rst_int_reg = 0; din = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit();
    exp_q.push_back(exp_do);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_do = '0; exp_pd = 0; exp_lpv = 0; exp_err = 0; exp_lerr = 0;
    bad_pkts = 0; m_hdr = '0;
  endtask

  // Check beat reaches the capture point: flags reflect the whole packet.
  task automatic capture(input logic [15:0] c, input logic [15:0] good);
    if (!exp_pd) begin
      exp_pd   = 1;
      exp_err  = (c != good);
      exp_lerr = (pay.size() != int'(m_hdr >> 2));
      if (exp_err || exp_lerr) bad_pkts++;
    end
  endtask

  task automatic header_cycle(input logic [15:0] hdr);
    int nch;
    nch = (phase == 0) ? 3 : 4;
    drive_clear(); detect_add = 1; pkt_valid = 1; din = hdr;
    step();
    if (int'(hdr & 16'h3) < nch) begin
      m_hdr = hdr; exp_pd = 0; exp_err = 0; exp_lerr = 0;
    end
    commit();
    drive_clear(); lfd_state = 1; pkt_valid = 1;
    step(); exp_do = m_hdr; commit();
  endtask

  // stall_at: payload index meeting a full FIFO (-1 none); flip: corrupt
  // check bit 0; chk_full: check beat meets a full FIFO.
  task automatic send_packet(input logic [15:0] hdr, input int stall_at, input bit flip, input bit chk_full);
    logic [15:0] good, c;
    header_cycle(hdr);
    for (int i = 0; i < pay.size(); i++) begin
      drive_clear(); ld_state = 1; pkt_valid = 1; din = pay[i]; fifo_full = (i == stall_at);
      step();
      if (i != stall_at) begin
        exp_do = pay[i]; commit();
      end else begin
        commit();
        drive_clear(); full_state = 1; fifo_full = 1; pkt_valid = 1; din = 16'h00A5;
        step(); commit();
        drive_clear(); laf_state = 1; pkt_valid = 1; din = 16'h005A;
        step(); exp_do = pay[i]; commit();
      end
    end
    good = model_check(m_hdr, (phase == 0) ? 8 : 16, phase == 1);
    c = good ^ {15'd0, flip};
    drive_clear(); ld_state = 1; pkt_valid = 0; din = c; fifo_full = chk_full;
    step(); exp_lpv = 1;
    if (!chk_full) begin
      exp_do = c; capture(c, good); commit();
    end else begin
      commit();
      drive_clear(); full_state = 1; fifo_full = 1;
      step(); commit();
      drive_clear(); laf_state = 1;
      step(); exp_do = c; capture(c, good); commit();
    end
    drive_clear(); rst_int_reg = 1;
    step(); exp_lpv = 0; commit();
    drive_clear();
  endtask

  task automatic bad_header(input logic [15:0] hdr);
    header_cycle(hdr);
    drive_clear(); rst_int_reg = 1;
    step(); commit();
    drive_clear();
  endtask

  task automatic fill_count(input int n);
    pay.delete();
    for (int i = 1; i <= n; i++) pay.push_back(16'(i));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_clear();
    #12;
    chk("reset_data_out", 32'(do0), 32'h0);
    chk("reset_flags", 32'({pd0, lpv0, er0, le0}), 32'h0);
    chk("reset_err_cnt", 32'(ec0), 32'h0);
    resetn = 1;
    cmp_en = 1;

    // 1: hdr 0x51 (len 20, addr 1), beats 1..20, clean
    fill_count(20);
    chk("pin_xor_check", 32'(model_check(16'h0051, 8, 0)), 32'h45);
    send_packet(16'h0051, -1, 0, 0);
    chk("t1_parity_done", 32'(pd0), 32'h1);
    chk("t1_data_out_check", 32'(do0), 32'h45);

    // 2: stall at payload beat 17, then check beat under a full FIFO
    send_packet(16'h0051, 16, 0, 0);
    chk("t2_err", 32'(er0), 32'h0);
    send_packet(16'h0051, -1, 0, 1);

    // 3: corrupted check beat, then a clean packet clears err
    send_packet(16'h0051, -1, 1, 0);
    chk("t3_err", 32'(er0), 32'h1);
    chk("t3_err_cnt", 32'(ec0), 32'h1);
    send_packet(16'h0051, 5, 0, 0);
    chk("t3_err_cleared", 32'(er0), 32'h0);
    chk("t3_err_cnt_kept", 32'(ec0), 32'h1);

    // another shape: len 8, addr 2
    pay.delete();
    pay.push_back(16'h3C); pay.push_back(16'h00); pay.push_back(16'hFF); pay.push_back(16'h5A);
    pay.push_back(16'h81); pay.push_back(16'h7E); pay.push_back(16'h10); pay.push_back(16'h01);
    send_packet(16'h0022, 3, 0, 0);

    // invalid address 3 with NUM_CH=3: header ignored, flags untouched
    bad_header(16'h0053);
    chk("t5_hdr_unchanged", 32'(do0), 32'h22);

    // 4: short packets (19 beats for len 20) -> len_err, counter saturation
    fill_count(19);
    for (int k = 0; k < 4; k++) send_packet(16'h0051, -1, 0, 0);
    chk("t4_len_err", 32'(le0), 32'h1);
    chk("t4_err_cnt_sat", 32'(ec1), 32'h3);
    chk("t4_err_cnt_wide", 32'(ec0), 32'h5);

    // 6: async reset mid-payload
    fill_count(20);
    header_cycle(16'h0051);
    for (int i = 0; i < 5; i++) begin
      drive_clear(); ld_state = 1; pkt_valid = 1; din = pay[i];
      step(); exp_do = pay[i]; commit();
    end
    #2;
    resetn = 0;
    #1;
    chk("t6_async_data_out", 32'(do0), 32'h0);
    chk("t6_async_flags", 32'({pd0, lpv0, er0, le0}), 32'h0);
    chk("t6_async_err_cnt0", 32'(ec0), 32'h0);
    chk("t6_async_err_cnt1", 32'(ec1), 32'h0);
    drive_clear();
    clear_model();
    @(negedge clk);
    #2;
    resetn = 1;
    send_packet(16'h0051, -1, 0, 0);
    chk("t6_clean_after_reset", 32'({pd0, er0, le0}), 32'h4);

    // 5: 16-bit rotate-XOR instance
    @(negedge clk);
    #1;
    resetn = 0;
    phase = 1;
    clear_model();
    #2;
    resetn = 1;
    pay.delete();
    pay.push_back(16'h0001); pay.push_back(16'h8000); pay.push_back(16'h0003);
    chk("pin_rotxor_check", 32'(model_check(16'h000F, 16, 1)), 32'h007E);
    send_packet(16'h000F, -1, 0, 0);
    chk("t5_rot_data_out", 32'(do2), 32'h007E);
    chk("t5_rot_err", 32'(er2), 32'h0);
    pay.delete();
    pay.push_back(16'h1234); pay.push_back(16'hFFFF); pay.push_back(16'h8001);
    pay.push_back(16'h00F0); pay.push_back(16'hABCD);
    send_packet(16'h0016, 2, 0, 1);
    send_packet(16'h0017, -1, 1, 0);
    chk("t5_rot_flip_err", 32'(er2), 32'h1);

    repeat (2) @(posedge clk);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
